// File: rtl/ifetch_pkg.sv
// Shared constants and payload types for the instruction-fetch front end.
package ifetch_pkg;

  localparam int unsigned IADDRWIDTH = 16;
  localparam int unsigned IWIDTH     = 16;

  typedef struct packed {
    logic [IWIDTH-1:0]     instr;
    logic [IADDRWIDTH-1:0] pc;
  } fetch_entry_t;

  // Occupancy counter width: must hold the value DEPTH itself.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries with single-cycle flush.
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  fetch_entry_t         push_data,
  input  logic                 pop,
  input  logic                 flush,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t         head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  fetch_entry_t   mem_d [DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push, do_pop;

  // Pointer/occupancy update; flush wins over any push or pop of the cycle.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_prefetch.sv
// Instruction prefetch front end: credit-based issue to a 1-cycle imem,
// FIFO buffering toward decode, redirect flush. Optional IFETCH_BYPASS_EN
// forwards a response straight to decode when the FIFO is empty.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int unsigned            DEPTH    = 4,
  parameter logic [IADDRWIDTH-1:0]  RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [IADDRWIDTH-1:0]   imem_addr,
  output logic                    imem_req,
  input  logic [IWIDTH-1:0]       imem_data,
  input  logic                    redirect,
  input  logic [IADDRWIDTH-1:0]   redirect_pc,
  output logic                    out_valid,
  output logic [IWIDTH-1:0]       out_instr,
  output logic [IADDRWIDTH-1:0]   out_pc,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned CW = cnt_width(DEPTH);

  logic [IADDRWIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [IADDRWIDTH-1:0] issued_pc_q, issued_pc_d;
  logic                  inflight_q, inflight_d;
  logic                  squash_q, squash_d;

  logic [CW-1:0]         count;
  fetch_entry_t          head;
  fetch_entry_t          resp;
  logic                  resp_valid;
  logic                  credit_ok;
  logic                  push, pop;

  // Credit counts the in-flight word but not a same-cycle pop, so no overflow.
  assign credit_ok = (count + CW'(inflight_q)) < CW'(DEPTH);

  // Issue: a redirect always re-issues since the flush frees every entry.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    if (!rst) begin
      if (redirect) begin
        imem_req  = 1'b1;
        imem_addr = redirect_pc;
      end else begin
        imem_req  = credit_ok;
      end
    end
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = imem_req;
    // Only a redirect that could not re-issue leaves a stale response behind.
    squash_d    = redirect && !imem_req;
    if (imem_req) begin
      fetch_pc_d  = imem_addr + IADDRWIDTH'(1);
      issued_pc_d = imem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
      squash_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
      squash_q    <= squash_d;
    end
  end

  assign resp_valid = inflight_q && !squash_q;
  assign resp       = '{instr: imem_data, pc: issued_pc_q};

`ifdef IFETCH_BYPASS_EN
  logic bypass;

  // Empty FIFO: present the arriving word directly; write it only if not taken.
  assign bypass    = resp_valid && !rst && (count == '0);
  assign out_valid = (count != '0) || bypass;
  assign out_instr = bypass ? resp.instr : head.instr;
  assign out_pc    = bypass ? resp.pc    : head.pc;
  assign push      = resp_valid && !redirect && !(bypass && out_ready);
  assign pop       = (count != '0) && out_ready && !redirect;
`else
  assign out_valid = (count != '0);
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign push      = resp_valid && !redirect;
  assign pop       = out_valid && out_ready && !redirect;
`endif

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(resp),
    .pop      (pop),
    .flush    (redirect),
    .count    (count),
    .head     (head)
  );

  assign fifo_count = count;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Scoreboard bench for ifetch_prefetch: expected PC streams are queued from
// reset/redirect stimulus and checked by a separate negedge monitor.
module tb_ifetch_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;
`ifdef IFETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic [15:0] imem_data = '0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic        out_ready = 1'b1;
  logic [2:0]  fifo_count;

  ifetch_prefetch #(
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Behavioural instruction memory: word = addr ^ A5A5, one cycle later.
  always @(posedge clk) imem_data <= imem_addr ^ 16'hA5A5;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard state
  logic [15:0] redir_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] exp_tail;

  task automatic load_stream(input logic [15:0] start);
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(start + 16'(i));
    exp_tail = start + 16'd4;
  endtask

  int          age = 1000;
  logic [15:0] tgt = '0;
  bit          prev_rst = 1'b1;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_pc, prev_instr, mon_e;

  // Monitor: compares every handshake and latency/hold rule against the model.
  always @(negedge clk) begin
    if (rst) begin
      load_stream(RESET_PC);
      age        = 1000;
      prev_rst   = 1'b1;
      prev_stall = 1'b0;
    end else begin
      if (prev_rst) begin
        chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
        chk(fifo_count == 3'd0, "rst_fifo_count", 32'(fifo_count), 32'd0);
        chk(out_pc == 16'd0 && out_instr == 16'd0, "rst_out_data", {out_pc, out_instr}, 32'd0);
        chk(imem_req == 1'b1, "rst_first_req", 32'(imem_req), 32'd1);
        chk(imem_addr == (redirect ? redirect_pc : RESET_PC), "rst_first_addr",
            32'(imem_addr), 32'(redirect ? redirect_pc : RESET_PC));
      end
      if (age >= 1 && age < LAT)
        chk(out_valid == 1'b0, "restart_early_valid", 32'(out_valid), 32'd0);
      if (age == LAT)
        chk(out_valid && out_pc == tgt, "restart_first_pc", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, tgt});
      chk(fifo_count <= 3'(DEPTH), "fifo_bound", 32'(fifo_count), 32'(DEPTH));
      if (prev_stall)
        chk(out_valid && out_pc == prev_pc && out_instr == prev_instr, "stall_hold",
            {out_pc, out_instr}, {prev_pc, prev_instr});
      if (out_valid && out_ready) begin
        mon_e = exp_q.pop_front();
        exp_q.push_back(exp_tail);
        exp_tail = exp_tail + 16'd1;
        chk(out_pc == mon_e, "pc_order", 32'(out_pc), 32'(mon_e));
        chk(out_instr == (mon_e ^ 16'hA5A5), "instr_word", 32'(out_instr), 32'(mon_e ^ 16'hA5A5));
      end
      if (redirect) begin
        if (redir_q.size() == 0) begin
          chk(1'b0, "redir_queue_empty", 32'(redirect_pc), 32'd0);
        end else begin
          tgt = redir_q.pop_front();
          load_stream(tgt);
        end
        age = 1;
      end else if (prev_rst) begin
        tgt = RESET_PC;
        age = 1;
      end else if (age < 1000) begin
        age++;
      end
      prev_stall = out_valid && !out_ready && !redirect;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      prev_rst   = 1'b0;
    end
  end

  task automatic cyc(input bit r, input bit rd, input bit red, input logic [15:0] rpc);
    @(posedge clk);
    #1;
    rst         = r;
    out_ready   = rd;
    redirect    = red;
    redirect_pc = rpc;
    if (red) redir_q.push_back(rpc);
  endtask

  initial begin
    // Streaming from reset with decode always ready
    repeat (3) cyc(1, 1, 0, 0);
    for (int k = 0; k < 12; k++) begin
      cyc(0, 1, 0, 0);
      @(negedge clk);
      if (k >= LAT) chk(out_valid == 1'b1, "stream_valid", 32'(out_valid), 32'd1);
    end

    // Stall: FIFO fills to DEPTH, issue stops, head held
    repeat (2) cyc(1, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 0);
    @(negedge clk);
    chk(fifo_count == 3'(DEPTH), "full_count", 32'(fifo_count), 32'(DEPTH));
    chk(imem_req == 1'b0, "full_no_req", 32'(imem_req), 32'd0);
    chk(out_valid && out_pc == 16'h0000, "full_head", {15'd0, out_valid, out_pc}, {15'd0, 1'b1, 16'h0000});
    repeat (12) cyc(0, 1, 0, 0);

    // Redirect with 3 buffered and one in flight
    repeat (2) cyc(1, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 16'h0100);
    @(negedge clk);
    chk(fifo_count == 3'd3, "pre_redirect_count", 32'(fifo_count), 32'd3);
    repeat (10) cyc(0, 1, 0, 0);

    // Back-to-back redirects
    cyc(0, 1, 1, 16'h0200);
    cyc(0, 1, 1, 16'h0300);
    repeat (8) cyc(0, 1, 0, 0);

    // Address wrap-around
    cyc(0, 1, 1, 16'hFFFE);
    repeat (8) cyc(0, 1, 0, 0);

    // Reset pulse while full
    repeat (10) cyc(0, 0, 0, 0);
    @(negedge clk);
    chk(fifo_count == 3'(DEPTH), "full_before_rst", 32'(fifo_count), 32'(DEPTH));
    cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 1, 0, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      automatic bit r   = ($urandom_range(0, 99) == 0);
      automatic bit red = !r && ($urandom_range(0, 15) == 0);
      automatic bit rd  = ($urandom_range(0, 3) != 0);
      cyc(r, rd, red, 16'($urandom));
    end
    repeat (6) cyc(0, 1, 0, 0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
